return_addr_stack: RTL and testbench
====================================

# return_addr_stack

Hardware return-address stack for the CPU fetch path. It complements the program counter. The counter produces addresses; this block saves a return address on CALL (push) and hands it back on RET (pop) so the counter can be reloaded through its `Initial`/`Reset` load path. Storage is a register-file LIFO with full/empty status, an occupancy count and sticky error flags.

## Interface
- `SIZE`, 8: address width in bits; matches the program-counter width.
- `DEPTH`, 8: number of entries; power of two, ≥ 2.
- `CW` (localparam), `$clog2(DEPTH+1)`: width of `Count`.

Ports:
- `Clock` input 1: single clock; all state changes on its rising edge.
- `Reset` input 1: asynchronous, active-high; clears all state immediately.
- `Push` input 1: request to save `Push_Addr` this cycle.
- `Push_Addr` input SIZE: return address to save.
- `Pop` input 1: request to retrieve the most recent address.
- `Clear_Flags` input 1: synchronous clear of `Overflow` and `Underflow`.
- `Pop_Addr` output SIZE: registered popped address.
- `Pop_Valid` output 1: one-cycle pulse; `Pop_Addr` is valid this cycle.
- `Count` output CW: current number of valid entries (0..DEPTH).
- `Empty` output 1: `Count == 0`.
- `Full` output 1: `Count == DEPTH`.
- `Overflow` output 1: sticky flag; a push occurred while full.
- `Underflow` output 1: sticky flag; a pop occurred while empty.

## Operation
- State: entry array `mem[DEPTH]`, top pointer `tp` (index of next free slot, mod DEPTH), `Count`, output registers.
- Push only, not full: `mem[tp] <= Push_Addr`, `tp <= tp+1`, `Count <= Count+1`.
- Pop only, not empty: `Pop_Addr <= mem[tp-1]`, `Pop_Valid <= 1`, `tp <= tp-1`, `Count <= Count-1`.
- Pop while empty: `Pop_Valid <= 0`, `Pop_Addr` holds, `Underflow <= 1`, pointer and count unchanged.
- Push and Pop together, not empty:
  - `Pop_Addr <= mem[tp-1]` (old top), `Pop_Valid <= 1`.
  - `mem[tp-1] <= Push_Addr`.
  - `tp` and `Count` unchanged; this holds also when full, with no `Overflow`.
- Push and Pop together, empty: treated as a pop-while-empty plus a push-only. `Underflow <= 1`, `Pop_Valid <= 0`, entry written, `Count <= 1`.
- Push while full: behaviour set by the macro in Configuration. `Overflow <= 1` in both builds.
- `Clear_Flags`: clears both sticky flags. If an error event occurs in the same cycle, setting wins.
- `Pop_Valid` is 0 in every cycle without a successful pop.
- `Empty` and `Full` are decoded combinationally from the `Count` register, so they are glitch-free after the edge.

## Timing
- Reset values:
  - `Pop_Addr` = 0, `Pop_Valid` = 0, `Count` = 0, `Empty` = 1, `Full` = 0, `Overflow` = 0, `Underflow` = 0.
  - `tp` = 0; `mem` contents are don't-care.
- Reset asserted mid-operation: all of the above take effect immediately and asynchronously. Push/pop requests sampled during reset are ignored.
- Push-to-visible latency: 1 cycle. `Count`, `Full` and `Empty` update on the edge that samples `Push`.
- Pop latency: 1 cycle. `Pop_Addr`/`Pop_Valid` are registered on the edge that samples `Pop`.
- Back-to-back pops on consecutive cycles return consecutive older entries. A push followed next cycle by a pop returns the pushed value.
- There is no backpressure. The consumer must accept `Pop_Addr` in the `Pop_Valid` cycle.

## Configuration
- `RAS_WRAP_EN` defined (circular mode):
  - Push while full overwrites the oldest entry: `mem[tp] <= Push_Addr`, `tp <= tp+1`.
  - `Count` stays DEPTH.
  - Subsequent pops return the newest DEPTH addresses in LIFO order.
- `RAS_WRAP_EN` undefined (saturating mode):
  - Push while full is dropped; `mem`, `tp` and `Count` are unchanged.
  - Stack contents are preserved.

## Test plan
- Reset check: assert `Reset` asynchronously between edges. Outputs take reset values before the next edge: `Empty`=1, `Count`=0, `Pop_Valid`=0.
- LIFO order: push 0x10, 0x20, 0x30 on consecutive cycles, then pop ×3. Expect `Pop_Addr` 0x30, 0x20, 0x10, each with `Pop_Valid`=1. After the last pop, `Count`=0 and `Empty`=1.
- Full and overflow: push 0x01..0x09 with DEPTH=8. `Full`=1 after the 8th push and `Overflow`=1 after the 9th.
  - Then pop once: saturating build returns 0x08; wrap build returns 0x09.
  - Pop to empty: wrap build's last pop is 0x02.
- Simultaneous push and pop with stack holding 0x10, 0x20: Push=0x55 and Pop in one cycle. `Pop_Addr`=0x20 and `Count` stays 2. The next pop returns 0x55.
- Underflow: pop while empty gives `Pop_Valid`=0 and `Underflow`=1, with `Count` still 0. Then assert `Clear_Flags` for 1 cycle and check `Underflow`=0.
- Reset mid-burst: push 3 entries, then assert `Reset` in the same cycle as a `Push`. After release, `Count`=0 and a pop sets `Underflow`.

Source files
------------

// File: rtl/return_addr_stack.sv
// Return-address LIFO for the fetch path: CALL pushes, RET pops into the PC reload path.
// Latency: push visible in Count/Full/Empty 1 cycle later; Pop_Addr/Pop_Valid registered 1 cycle after Pop.
// No backpressure: the consumer must take Pop_Addr in the Pop_Valid cycle. Macro RAS_WRAP_EN selects circular overwrite on push-while-full.
module return_addr_stack #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Push,
  input  logic [SIZE-1:0] Push_Addr,
  input  logic            Pop,
  input  logic            Clear_Flags,
  output logic [SIZE-1:0] Pop_Addr,
  output logic            Pop_Valid,
  output logic [CW-1:0]   Count,
  output logic            Empty,
  output logic            Full,
  output logic            Overflow,
  output logic            Underflow
);

  localparam int AW = $clog2(DEPTH);

  // Entry storage is not reset; only entries below the top pointer are ever read.
  logic [SIZE-1:0] mem_q [DEPTH];

  logic [AW-1:0]   tp_q, tp_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SIZE-1:0] pop_addr_q, pop_addr_d;
  logic            pop_valid_q, pop_valid_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;

  logic            wr_en;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   tp_m1;
  logic            empty_w, full_w;

  // Status is decoded from the count register only, so it settles right after the edge.
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));
  assign tp_m1   = tp_q - AW'(1);

  // Next-state: pop has priority over push for pointer movement; a combined
  // push+pop on a non-empty stack replaces the top entry in place.
  always_comb begin
    tp_d        = tp_q;
    count_d     = count_q;
    pop_addr_d  = pop_addr_q;
    pop_valid_d = 1'b0;
    ovf_d       = ovf_q & ~Clear_Flags;
    udf_d       = udf_q & ~Clear_Flags;
    wr_en       = 1'b0;
    wr_idx      = tp_q;

    if (Pop && !empty_w) begin
      pop_addr_d  = mem_q[tp_m1];
      pop_valid_d = 1'b1;
      if (Push) begin
        // Replace: old top leaves, new address takes its slot; depth unchanged even when full.
        wr_en  = 1'b1;
        wr_idx = tp_m1;
      end else begin
        tp_d    = tp_m1;
        count_d = count_q - CW'(1);
      end
    end else begin
      // Pop on an empty stack only raises the flag; any push this cycle proceeds normally.
      if (Pop) begin
        udf_d = 1'b1;
      end
      if (Push) begin
        if (!full_w) begin
          wr_en   = 1'b1;
          tp_d    = tp_q + AW'(1);
          count_d = count_q + CW'(1);
        end else begin
          ovf_d = 1'b1;
`ifdef RAS_WRAP_EN
          // Circular: the slot at tp holds the oldest entry once full, so it is overwritten.
          wr_en = 1'b1;
          tp_d  = tp_q + AW'(1);
`else
          // Saturating: drop the push and keep the existing contents intact.
          wr_en = 1'b0;
`endif
        end
      end
    end
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tp_q        <= '0;
      count_q     <= '0;
      pop_addr_q  <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      tp_q        <= tp_d;
      count_q     <= count_d;
      pop_addr_q  <= pop_addr_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  // Entry write port; requests seen while Reset is high are ignored.
  always_ff @(posedge Clock) begin
    if (wr_en && !Reset) begin
      mem_q[wr_idx] <= Push_Addr;
    end
  end

  assign Pop_Addr  = pop_addr_q;
  assign Pop_Valid = pop_valid_q;
  assign Count     = count_q;
  assign Empty     = empty_w;
  assign Full      = full_w;
  assign Overflow  = ovf_q;
  assign Underflow = udf_q;

endmodule

// File: tb/tb_return_addr_stack.sv
module tb_return_addr_stack;

  localparam int SIZE  = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            Clock = 1'b0;
  logic            Reset;
  logic            Push;
  logic [SIZE-1:0] Push_Addr;
  logic            Pop;
  logic            Clear_Flags;
  logic [SIZE-1:0] Pop_Addr;
  logic            Pop_Valid;
  logic [CW-1:0]   Count;
  logic            Empty;
  logic            Full;
  logic            Overflow;
  logic            Underflow;

  int errors = 0;
  int checks = 0;

  return_addr_stack #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Push       (Push),
    .Push_Addr  (Push_Addr),
    .Pop        (Pop),
    .Clear_Flags(Clear_Flags),
    .Pop_Addr   (Pop_Addr),
    .Pop_Valid  (Pop_Valid),
    .Count      (Count),
    .Empty      (Empty),
    .Full       (Full),
    .Overflow   (Overflow),
    .Underflow  (Underflow)
  );

  always #5 Clock = ~Clock;

  // One clock with the given request inputs, sampled 1ns after the edge; inputs then return to idle.
  task automatic cyc(input logic push, input logic [SIZE-1:0] addr, input logic pop, input logic clr);
    Push = push; Push_Addr = addr; Pop = pop; Clear_Flags = clr;
    @(posedge Clock); #1;
    Push = 1'b0; Pop = 1'b0; Clear_Flags = 1'b0; Push_Addr = '0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if (Count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", Count); end checks++;
    if (Empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", Empty); end checks++;
    if (Full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", Full); end checks++;
    if (Pop_Addr !== 8'h00) begin errors++; $display("FAIL reset_pop_addr got=%h exp=00", Pop_Addr); end checks++;
    // Build up state, then assert Reset between edges and check it acts before the next edge.
    cyc(1'b1, 8'hA1, 1'b0, 1'b0);
    cyc(1'b1, 8'hA2, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    if (Pop_Valid !== 1'b1 || Pop_Addr !== 8'hA2) begin errors++; $display("FAIL pre_reset_pop got=%b/%h exp=1/a2", Pop_Valid, Pop_Addr); end checks++;
    #2 Reset = 1'b1;
    #1;
    if (Count !== 4'd0) begin errors++; $display("FAIL async_reset_count got=%0d exp=0", Count); end checks++;
    if (Empty !== 1'b1) begin errors++; $display("FAIL async_reset_empty got=%b exp=1", Empty); end checks++;
    if (Pop_Valid !== 1'b0) begin errors++; $display("FAIL async_reset_pop_valid got=%b exp=0", Pop_Valid); end checks++;
    if (Pop_Addr !== 8'h00) begin errors++; $display("FAIL async_reset_pop_addr got=%h exp=00", Pop_Addr); end checks++;
    @(posedge Clock); #1;
    Reset = 1'b0;
  endtask

  task automatic test_lifo();
    logic [SIZE-1:0] exp_pop [3];
    exp_pop[0] = 8'h30; exp_pop[1] = 8'h20; exp_pop[2] = 8'h10;
    do_reset();
    cyc(1'b1, 8'h10, 1'b0, 1'b0);
    if (Count !== 4'd1 || Empty !== 1'b0) begin errors++; $display("FAIL lifo_first_push got=%0d/%b exp=1/0", Count, Empty); end checks++;
    cyc(1'b1, 8'h20, 1'b0, 1'b0);
    cyc(1'b1, 8'h30, 1'b0, 1'b0);
    if (Count !== 4'd3) begin errors++; $display("FAIL lifo_count got=%0d exp=3", Count); end checks++;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      if (Pop_Valid !== 1'b1 || Pop_Addr !== exp_pop[i]) begin
        errors++; $display("FAIL lifo_pop%0d got=%b/%h exp=1/%h", i, Pop_Valid, Pop_Addr, exp_pop[i]);
      end
      checks++;
    end
    if (Count !== 4'd0 || Empty !== 1'b1) begin errors++; $display("FAIL lifo_drained got=%0d/%b exp=0/1", Count, Empty); end checks++;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    if (Pop_Valid !== 1'b0) begin errors++; $display("FAIL lifo_valid_pulse got=%b exp=0", Pop_Valid); end checks++;
  endtask

  task automatic test_full_overflow();
    logic [SIZE-1:0] first_pop, last_pop;
`ifdef RAS_WRAP_EN
    first_pop = 8'h09; last_pop = 8'h02;
`else
    first_pop = 8'h08; last_pop = 8'h01;
`endif
    do_reset();
    for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    if (Full !== 1'b1 || Count !== 4'd8) begin errors++; $display("FAIL full_after8 got=%b/%0d exp=1/8", Full, Count); end checks++;
    if (Overflow !== 1'b0) begin errors++; $display("FAIL no_overflow_yet got=%b exp=0", Overflow); end checks++;
    cyc(1'b1, 8'h09, 1'b0, 1'b0);
    if (Overflow !== 1'b1 || Count !== 4'd8) begin errors++; $display("FAIL overflow_after9 got=%b/%0d exp=1/8", Overflow, Count); end checks++;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    if (Pop_Valid !== 1'b1 || Pop_Addr !== first_pop) begin errors++; $display("FAIL full_first_pop got=%b/%h exp=1/%h", Pop_Valid, Pop_Addr, first_pop); end checks++;
    for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    if (Pop_Valid !== 1'b1 || Pop_Addr !== last_pop) begin errors++; $display("FAIL full_last_pop got=%b/%h exp=1/%h", Pop_Valid, Pop_Addr, last_pop); end checks++;
    if (Empty !== 1'b1 || Overflow !== 1'b1) begin errors++; $display("FAIL full_drained got=%b/%b exp=1/1", Empty, Overflow); end checks++;
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    if (Overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear got=%b exp=0", Overflow); end checks++;
  endtask

  task automatic test_simul_push_pop();
    do_reset();
    cyc(1'b1, 8'h10, 1'b0, 1'b0);
    cyc(1'b1, 8'h20, 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    if (Pop_Valid !== 1'b1 || Pop_Addr !== 8'h20) begin errors++; $display("FAIL simul_pop got=%b/%h exp=1/20", Pop_Valid, Pop_Addr); end checks++;
    if (Count !== 4'd2) begin errors++; $display("FAIL simul_count got=%0d exp=2", Count); end checks++;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    if (Pop_Addr !== 8'h55 || Count !== 4'd1) begin errors++; $display("FAIL simul_next_pop got=%h/%0d exp=55/1", Pop_Addr, Count); end checks++;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    if (Pop_Addr !== 8'h10 || Empty !== 1'b1) begin errors++; $display("FAIL simul_last_pop got=%h/%b exp=10/1", Pop_Addr, Empty); end checks++;
    // Combined push+pop on a full stack replaces the top without raising Overflow.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    if (Pop_Addr !== 8'h47 || Count !== 4'd8 || Overflow !== 1'b0) begin
      errors++; $display("FAIL simul_full got=%h/%0d/%b exp=47/8/0", Pop_Addr, Count, Overflow);
    end
    checks++;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    if (Pop_Addr !== 8'h77) begin errors++; $display("FAIL simul_full_next got=%h exp=77", Pop_Addr); end checks++;
  endtask

  task automatic test_underflow();
    do_reset();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    if (Pop_Valid !== 1'b0 || Underflow !== 1'b1 || Count !== 4'd0) begin
      errors++; $display("FAIL underflow got=%b/%b/%0d exp=0/1/0", Pop_Valid, Underflow, Count);
    end
    checks++;
    if (Pop_Addr !== 8'h00) begin errors++; $display("FAIL underflow_hold got=%h exp=00", Pop_Addr); end checks++;
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    if (Underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear got=%b exp=0", Underflow); end checks++;
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    if (Underflow !== 1'b1) begin errors++; $display("FAIL set_beats_clear got=%b exp=1", Underflow); end checks++;
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    // Push+pop on an empty stack: underflow plus a normal push.
    cyc(1'b1, 8'h66, 1'b1, 1'b0);
    if (Pop_Valid !== 1'b0 || Underflow !== 1'b1 || Count !== 4'd1) begin
      errors++; $display("FAIL simul_empty got=%b/%b/%0d exp=0/1/1", Pop_Valid, Underflow, Count);
    end
    checks++;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    if (Pop_Valid !== 1'b1 || Pop_Addr !== 8'h66) begin errors++; $display("FAIL simul_empty_pop got=%b/%h exp=1/66", Pop_Valid, Pop_Addr); end checks++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    Reset = 1'b1;
    cyc(1'b1, 8'h44, 1'b0, 1'b0);
    Reset = 1'b0;
    if (Count !== 4'd0 || Empty !== 1'b1) begin errors++; $display("FAIL midburst_count got=%0d/%b exp=0/1", Count, Empty); end checks++;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    if (Underflow !== 1'b1 || Pop_Valid !== 1'b0) begin errors++; $display("FAIL midburst_underflow got=%b/%b exp=1/0", Underflow, Pop_Valid); end checks++;
  endtask

  initial begin
    Reset = 1'b1; Push = 1'b0; Push_Addr = '0; Pop = 1'b0; Clear_Flags = 1'b0;
    #1;
    if (Empty !== 1'b1 || Count !== 4'd0 || Pop_Valid !== 1'b0) begin
      errors++; $display("FAIL power_on_reset got=%b/%0d/%b exp=1/0/0", Empty, Count, Pop_Valid);
    end
    checks++;
    test_reset();
    test_lifo();
    test_full_overflow();
    test_simul_push_pop();
    test_underflow();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
